rply_bias_seq: RTL and testbench

- Digital power-up sequencer and channel controller for the parametrised bias current-mirror array.
- Drives the mirror's active-low power-up switch, waits for the reference branch to settle, then enables output channels one at a time to limit inrush.
- Each channel's current is set by a thermometer-coded count of unit mirror cells.
- Sits between the register interface and the analog bias macro, with NCH output channels.

---
 rtl/rply_bias_seq.sv | 139 +++++++++++++
 tb/tb_rply_bias_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rply_bias_seq.sv
// Bias mirror power-up sequencer: settles the reference branch, then
// ramps channels on one slot at a time and drives thermometer unit gates.
module rply_bias_seq #(
    parameter int NCH        = 6,
    parameter int CODE_W     = 3,
    parameter int SETTLE_CYC = 64,
    parameter int STEP_CYC   = 8
) (
    input  logic                      CK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      CFG_VALID,
    output logic                      CFG_READY,
    input  logic [NCH-1:0]            CFG_CH_EN,
    input  logic [NCH*CODE_W-1:0]     CFG_CODE,
    output logic                      PWRUP_N,
    output logic [NCH*(2**CODE_W-1)-1:0] IBP_EN_N,
    output logic                      BUSY,
    output logic                      READY
);

    localparam int UNITS = 2**CODE_W - 1;
    localparam int MAXC  = (SETTLE_CYC > STEP_CYC*NCH) ? SETTLE_CYC
                                                       : STEP_CYC*NCH;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_START,
        S_RAMP,
        S_ON,
        S_SHUT
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [NCH-1:0]          mask;
    logic [NCH-1:0]          sh_en;
    logic [NCH*CODE_W-1:0]   sh_code;
    logic [NCH-1:0]          mask_nx;
    logic                    cfg_acc;

    // mask holds the ramp-enabled channels; the next slot adds one more bit
    assign mask_nx = (mask << 1) | NCH'(1);
    assign cfg_acc = CFG_VALID && CFG_READY;

    function automatic logic [NCH*UNITS-1:0] units_n(
        input logic [NCH-1:0]        act,
        input logic [NCH*CODE_W-1:0] code
    );
        logic [NCH*UNITS-1:0] r;
        r = '1;
        for (int i = 0; i < NCH; i++) begin
            for (int j = 0; j < UNITS; j++) begin
                if (act[i] && j < int'(code[i*CODE_W +: CODE_W]))
                    r[i*UNITS + j] = 1'b0;
            end
        end
        return r;
    endfunction

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= S_OFF;
            cnt       <= '0;
            mask      <= '0;
            sh_en     <= '0;
            sh_code   <= '0;
            PWRUP_N   <= 1'b1;
            IBP_EN_N  <= '1;
            READY     <= 1'b0;
            BUSY      <= 1'b0;
            CFG_READY <= 1'b1;
        end else begin
            if (cfg_acc) begin
                sh_en   <= CFG_CH_EN;
                sh_code <= CFG_CODE;
            end
            unique case (state)
                S_OFF: begin
                    if (EN) begin
                        state     <= S_START;
                        cnt       <= '0;
                        PWRUP_N   <= 1'b0;
                        BUSY      <= 1'b1;
                        CFG_READY <= 1'b0;
                    end
                end
                S_START, S_RAMP, S_ON: begin
                    if (!EN) begin
                        state     <= S_SHUT;
                        mask      <= '0;
                        IBP_EN_N  <= '1;
                        READY     <= 1'b0;
                        BUSY      <= 1'b1;
                        CFG_READY <= 1'b0;
                    end else if (state == S_START) begin
                        if (cnt == CW'(SETTLE_CYC - 1)) begin
                            state    <= S_RAMP;
                            cnt      <= '0;
                            mask     <= NCH'(1);
                            IBP_EN_N <= units_n(NCH'(1) & sh_en, sh_code);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (state == S_RAMP) begin
                        if (cnt == CW'(STEP_CYC - 1)) begin
                            cnt <= '0;
                            if (mask[NCH-1]) begin
                                state     <= S_ON;
                                READY     <= 1'b1;
                                BUSY      <= 1'b0;
                                CFG_READY <= 1'b1;
                            end else begin
                                mask     <= mask_nx;
                                IBP_EN_N <= units_n(mask_nx & sh_en, sh_code);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        // current shadow, so an accept shows one edge later
                        IBP_EN_N <= units_n(mask & sh_en, sh_code);
                    end
                end
                S_SHUT: begin
                    state     <= S_OFF;
                    PWRUP_N   <= 1'b1;
                    BUSY      <= 1'b0;
                    CFG_READY <= 1'b1;
                end
                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rply_bias_seq.sv
// Randomized bench for rply_bias_seq against a time-since-start
// behavioural model of the power-up sequence.
module tb_rply_bias_seq;

    localparam int NCH        = 6;
    localparam int CODE_W     = 3;
    localparam int SETTLE_CYC = 64;
    localparam int STEP_CYC   = 8;
    localparam int UNITS      = 2**CODE_W - 1;
    localparam int T_ON       = SETTLE_CYC + STEP_CYC*NCH;

    logic                    CK = 1'b0;
    logic                    RST = 1'b1;
    logic                    EN = 1'b0;
    logic                    CFG_VALID = 1'b0;
    logic                    CFG_READY;
    logic [NCH-1:0]          CFG_CH_EN = '0;
    logic [NCH*CODE_W-1:0]   CFG_CODE = '0;
    logic                    PWRUP_N;
    logic [NCH*UNITS-1:0]    IBP_EN_N;
    logic                    BUSY;
    logic                    READY;

    int n_chk = 0;
    int n_err = 0;

    // model: mode 0 idle, 1 sequencing (t = edges since START entry), 2 shut
    int                    mode = 0;
    int                    t = 0;
    logic [NCH-1:0]        m_en = '0;
    logic [NCH*CODE_W-1:0] m_code = '0;

    rply_bias_seq #(
        .NCH(NCH), .CODE_W(CODE_W),
        .SETTLE_CYC(SETTLE_CYC), .STEP_CYC(STEP_CYC)
    ) dut (
        .CK(CK), .RST(RST), .EN(EN),
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_CH_EN(CFG_CH_EN), .CFG_CODE(CFG_CODE),
        .PWRUP_N(PWRUP_N), .IBP_EN_N(IBP_EN_N),
        .BUSY(BUSY), .READY(READY)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // one clock edge: advance the model with the inputs seen at the edge,
    // then compare every output just after it
    task automatic step();
        logic [NCH-1:0]        pen;
        logic [NCH*CODE_W-1:0] pcode;
        logic                  rdy_before;
        logic [NCH*UNITS-1:0]  e_ibp;
        logic [UNITS-1:0]      u;
        int                    k;
        logic                  on;
        @(posedge CK);
        pen        = m_en;
        pcode      = m_code;
        rdy_before = (mode == 0) || (mode == 1 && t >= T_ON);
        if (RST) begin
            mode   = 0;
            t      = 0;
            m_en   = '0;
            m_code = '0;
        end else begin
            if (CFG_VALID && rdy_before) begin
                m_en   = CFG_CH_EN;
                m_code = CFG_CODE;
            end
            case (mode)
                0: if (EN) begin mode = 1; t = 0; end
                1: if (!EN) mode = 2; else if (t < 100000) t++;
                default: mode = 0;
            endcase
        end
        on    = (mode == 1) && (t >= T_ON);
        e_ibp = '1;
        if (mode == 1) begin
            for (int i = 0; i < NCH; i++) begin
                if (pen[i] && t >= SETTLE_CYC + STEP_CYC*i) begin
                    k = int'(pcode[i*CODE_W +: CODE_W]);
                    u = ~UNITS'((1 << k) - 1);
                    e_ibp[i*UNITS +: UNITS] = u;
                end
            end
        end
        #1;
        chk("pwrup_n", 64'(PWRUP_N), 64'(mode == 0));
        chk("ibp_en_n", 64'(IBP_EN_N), 64'(e_ibp));
        chk("ready", 64'(READY), 64'(on));
        chk("busy", 64'(BUSY), 64'(mode != 0 && !on));
        chk("cfg_ready", 64'(CFG_READY), 64'(mode == 0 || on));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rnd_cfg();
        logic [31:0] r;
        r         = $urandom;
        CFG_CH_EN = r[NCH-1:0];
        r         = $urandom;
        CFG_CODE  = r[NCH*CODE_W-1:0];
    endtask

    initial begin
        // reset with EN high and a config offered that must be ignored
        EN        = 1'b1;
        CFG_VALID = 1'b1;
        CFG_CH_EN = '1;
        CFG_CODE  = '1;
        cyc(3);
        // first edge after release: accept CH_EN=3F codes 3, start settle
        RST       = 1'b0;
        CFG_CH_EN = 6'h3F;
        CFG_CODE  = {NCH{3'd3}};
        step();
        CFG_VALID = 1'b0;
        cyc(T_ON + 5);
        chk("on_after_ramp", 64'(READY), 64'd1);

        // sparse channel enable, full codes
        EN = 1'b0;
        cyc(2);
        CFG_VALID = 1'b1;
        CFG_CH_EN = 6'b000101;
        CFG_CODE  = {NCH{3'd7}};
        step();
        CFG_VALID = 1'b0;
        EN        = 1'b1;
        cyc(T_ON + 5);

        // alternating codes while ON
        for (int i = 0; i < 8; i++) begin
            CFG_VALID = 1'b1;
            CFG_CH_EN = '1;
            CFG_CODE  = (i % 2 == 0) ? '0 : {NCH{3'd7}};
            step();
        end
        CFG_VALID = 1'b0;
        cyc(3);

        // drop EN after channel 2 has ramped on
        EN = 1'b0;
        cyc(3);
        EN = 1'b1;
        cyc(SETTLE_CYC + 2*STEP_CYC + 3);
        EN = 1'b0;
        cyc(4);

        // one-cycle EN pulse low while ON
        EN = 1'b1;
        cyc(T_ON + 3);
        EN = 1'b0;
        step();
        EN = 1'b1;
        cyc(T_ON + 4);

        // reset during ON, then during START, config offered under reset
        RST       = 1'b1;
        CFG_VALID = 1'b1;
        rnd_cfg();
        step();
        RST = 1'b0;
        CFG_VALID = 1'b0;
        cyc(20);
        RST       = 1'b1;
        CFG_VALID = 1'b1;
        step();
        RST       = 1'b0;
        CFG_VALID = 1'b0;
        cyc(5);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            RST       = ($urandom_range(0, 299) == 0);
            EN        = ($urandom_range(0, 199) != 0);
            CFG_VALID = ($urandom_range(0, 2) == 0);
            rnd_cfg();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
